// File: rtl/pri_icache_ctrl_seq_if.sv
// Command and per-core control/counter bundle between the cluster register file
// and the private icache command sequencer.
interface pri_icache_ctrl_seq_if #(
    parameter int NB_CORES = 8,
    parameter int CNT_W    = 32,
    parameter int SUM_W    = CNT_W + $clog2(NB_CORES)
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [2:0]                cmd_op_i;
    logic [NB_CORES-1:0]       cmd_mask_i;
    logic                      done_o;
    logic                      err_o;
    logic [NB_CORES-1:0]       perf_en_i;
    logic [NB_CORES-1:0]       bypass_req_o;
    logic [NB_CORES-1:0]       bypass_ack_i;
    logic [NB_CORES-1:0]       flush_req_o;
    logic [NB_CORES-1:0]       flush_ack_i;
    logic [NB_CORES-1:0]       ctrl_clear_regs_o;
    logic [NB_CORES-1:0]       ctrl_enable_regs_o;
    logic [NB_CORES*CNT_W-1:0] hit_count_i;
    logic [NB_CORES*CNT_W-1:0] trans_count_i;
    logic [NB_CORES*CNT_W-1:0] miss_count_i;
    logic [SUM_W-1:0]          hit_sum_o;
    logic [SUM_W-1:0]          trans_sum_o;
    logic [SUM_W-1:0]          miss_sum_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_mask_i, perf_en_i, bypass_ack_i, flush_ack_i,
               hit_count_i, trans_count_i, miss_count_i,
        output cmd_ready_o, done_o, err_o, bypass_req_o, flush_req_o, ctrl_clear_regs_o,
               ctrl_enable_regs_o, hit_sum_o, trans_sum_o, miss_sum_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_mask_i, perf_en_i, bypass_ack_i, flush_ack_i,
               hit_count_i, trans_count_i, miss_count_i,
        input  cmd_ready_o, done_o, err_o, bypass_req_o, flush_req_o, ctrl_clear_regs_o,
               ctrl_enable_regs_o, hit_sum_o, trans_sum_o, miss_sum_o
    );
endinterface

// File: rtl/pri_icache_ctrl_seq.sv
// Private icache command sequencer: one masked command at a time drives per-core
// bypass/flush/clear lines and accumulates per-core perf counters into totals.
module pri_icache_ctrl_seq #(
    parameter int NB_CORES = 8,
    parameter int CNT_W    = 32,
    parameter int SUM_W    = CNT_W + $clog2(NB_CORES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pri_icache_ctrl_seq_if.slave  bus
);
    localparam int IDX_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    localparam logic [2:0] OP_BYP_SET = 3'd0;
    localparam logic [2:0] OP_BYP_CLR = 3'd1;
    localparam logic [2:0] OP_FLUSH   = 3'd2;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
    localparam logic [2:0] OP_SUM     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYP_WAIT,
        S_FLUSH_WAIT,
        S_CLEAR,
        S_SUM,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [NB_CORES-1:0] r_mask;
    logic [IDX_W-1:0]    r_idx;
    logic [NB_CORES-1:0] r_byp_req;
    logic [NB_CORES-1:0] r_flush_req;
    logic [NB_CORES-1:0] r_clear;
    logic [NB_CORES-1:0] r_enable;
    logic                r_done;
    logic                r_err;
    logic [SUM_W-1:0]    r_hit_sum;
    logic [SUM_W-1:0]    r_trans_sum;
    logic [SUM_W-1:0]    r_miss_sum;

    logic [CNT_W-1:0]    w_hit;
    logic [CNT_W-1:0]    w_trans;
    logic [CNT_W-1:0]    w_miss;
    logic [NB_CORES-1:0] w_flush_left;
    logic                w_byp_match;
    logic                w_last_idx;

    // Counters of the core currently walked by the SUM sequence.
    assign w_hit   = bus.hit_count_i[r_idx*CNT_W +: CNT_W];
    assign w_trans = bus.trans_count_i[r_idx*CNT_W +: CNT_W];
    assign w_miss  = bus.miss_count_i[r_idx*CNT_W +: CNT_W];

    assign w_flush_left = r_flush_req & ~bus.flush_ack_i;
    assign w_byp_match  = ((bus.bypass_ack_i ^ r_byp_req) & r_mask) == '0;
    assign w_last_idx   = (r_idx == IDX_W'(NB_CORES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_idx       <= '0;
            r_byp_req   <= '0;
            r_flush_req <= '0;
            r_clear     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_hit_sum   <= '0;
            r_trans_sum <= '0;
            r_miss_sum  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_mask <= bus.cmd_mask_i;
                        case (bus.cmd_op_i)
                            OP_BYP_SET: begin
                                r_byp_req <= r_byp_req | bus.cmd_mask_i;
                                r_state   <= S_BYP_WAIT;
                            end
                            OP_BYP_CLR: begin
                                r_byp_req <= r_byp_req & ~bus.cmd_mask_i;
                                r_state   <= S_BYP_WAIT;
                            end
                            OP_FLUSH: begin
                                r_flush_req <= bus.cmd_mask_i;
                                r_state     <= S_FLUSH_WAIT;
                            end
                            OP_CLEAR: begin
                                r_clear <= bus.cmd_mask_i;
                                r_state <= S_CLEAR;
                            end
                            OP_SUM: begin
                                r_hit_sum   <= '0;
                                r_trans_sum <= '0;
                                r_miss_sum  <= '0;
                                r_idx       <= '0;
                                r_state     <= S_SUM;
                            end
                            default: begin
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_BYP_WAIT: begin
                    if (w_byp_match) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_FLUSH_WAIT: begin
                    r_flush_req <= w_flush_left;
                    if (w_flush_left == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_CLEAR: begin
                    r_clear <= '0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_SUM: begin
                    if (r_mask[r_idx]) begin
                        r_hit_sum   <= r_hit_sum + SUM_W'(w_hit);
                        r_trans_sum <= r_trans_sum + SUM_W'(w_trans);
                        r_miss_sum  <= r_miss_sum + SUM_W'(w_miss);
                    end
                    r_idx <= r_idx + 1'b1;
                    if (w_last_idx) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_enable <= '0;
        else       r_enable <= bus.perf_en_i;
    end

    assign bus.cmd_ready_o        = (r_state == S_IDLE);
    assign bus.done_o             = r_done;
    assign bus.err_o              = r_err;
    assign bus.bypass_req_o       = r_byp_req;
    assign bus.flush_req_o        = r_flush_req;
    assign bus.ctrl_clear_regs_o  = r_clear;
    assign bus.ctrl_enable_regs_o = r_enable;
    assign bus.hit_sum_o          = r_hit_sum;
    assign bus.trans_sum_o        = r_trans_sum;
    assign bus.miss_sum_o         = r_miss_sum;
endmodule

// File: tb/tb_pri_icache_ctrl_seq.sv
// Directed bench for pri_icache_ctrl_seq: a command-level reference model checked
// every cycle, plus literal expectations at the key cycles of each command.
module tb_pri_icache_ctrl_seq;
    localparam int NB    = 8;
    localparam int CW    = 32;
    localparam int SW    = CW + $clog2(NB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pri_icache_ctrl_seq_if #(.NB_CORES(NB), .CNT_W(CW), .SUM_W(SW)) bus ();

    pri_icache_ctrl_seq #(.NB_CORES(NB), .CNT_W(CW), .SUM_W(SW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [NB-1:0][CW-1:0] hit, trans, miss;
    assign bus.hit_count_i   = hit;
    assign bus.trans_count_i = trans;
    assign bus.miss_count_i  = miss;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: command-level view, sums computed in one go at accept time
    // (the bench holds the counters stable for the whole SUM command).
    localparam int K_IDLE = 0, K_BYP = 1, K_FLUSH = 2, K_CLEAR = 3, K_SUM = 4;
    bit            m_init = 0;
    int            m_kind = K_IDLE;
    int            m_left = 0;
    bit            m_sum_busy = 0;
    logic [NB-1:0] m_mask;
    logic          e_ready, e_done, e_err;
    logic [NB-1:0] e_byp, e_flush, e_clear, e_en;
    logic [SW-1:0] e_hit, e_trans, e_miss, t_hit, t_trans, t_miss;

    initial forever begin
        @(posedge clk);
        m_init = 1;
        if (rst) begin
            e_ready = 1; e_done = 0; e_err = 0; m_kind = K_IDLE; m_sum_busy = 0;
            e_byp = '0; e_flush = '0; e_clear = '0; e_en = '0;
            e_hit = '0; e_trans = '0; e_miss = '0;
        end else begin
            bit was_done;
            was_done = e_done;
            e_en = bus.perf_en_i;
            e_done = 0; e_err = 0; e_clear = '0;
            if (was_done) begin
                e_ready = 1; m_kind = K_IDLE;
            end else if (e_ready) begin
                if (bus.cmd_valid_i) begin
                    e_ready = 0;
                    m_mask = bus.cmd_mask_i;
                    case (bus.cmd_op_i)
                        3'd0: begin e_byp = e_byp | m_mask;  m_kind = K_BYP; end
                        3'd1: begin e_byp = e_byp & ~m_mask; m_kind = K_BYP; end
                        3'd2: begin e_flush = m_mask; m_kind = K_FLUSH; end
                        3'd3: begin e_clear = m_mask; m_kind = K_CLEAR; end
                        3'd4: begin
                            t_hit = '0; t_trans = '0; t_miss = '0;
                            for (int k = 0; k < NB; k++) if (m_mask[k]) begin
                                t_hit   += SW'(hit[k]);
                                t_trans += SW'(trans[k]);
                                t_miss  += SW'(miss[k]);
                            end
                            m_left = NB; m_kind = K_SUM; m_sum_busy = 1;
                        end
                        default: begin e_done = 1; e_err = 1; end
                    endcase
                end
            end else begin
                case (m_kind)
                    K_BYP:   if (((bus.bypass_ack_i ^ e_byp) & m_mask) == '0) e_done = 1;
                    K_FLUSH: begin
                        e_flush = e_flush & ~bus.flush_ack_i;
                        if (e_flush == '0) e_done = 1;
                    end
                    K_CLEAR: e_done = 1;
                    K_SUM: begin
                        m_left--;
                        if (m_left == 0) begin
                            e_done = 1; m_sum_busy = 0;
                            e_hit = t_hit; e_trans = t_trans; e_miss = t_miss;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("ready",  64'(bus.cmd_ready_o), 64'(e_ready));
            chk("done",   64'(bus.done_o), 64'(e_done));
            chk("err",    64'(bus.err_o), 64'(e_err));
            chk("byp",    64'(bus.bypass_req_o), 64'(e_byp));
            chk("flush",  64'(bus.flush_req_o), 64'(e_flush));
            chk("clear",  64'(bus.ctrl_clear_regs_o), 64'(e_clear));
            chk("enable", 64'(bus.ctrl_enable_regs_o), 64'(e_en));
            if (!m_sum_busy) begin
                chk("hit_sum",   64'(bus.hit_sum_o), 64'(e_hit));
                chk("trans_sum", 64'(bus.trans_sum_o), 64'(e_trans));
                chk("miss_sum",  64'(bus.miss_sum_o), 64'(e_miss));
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Presents a command in cycle 0; returns in cycle 1.
    task automatic issue(input logic [2:0] op, input logic [NB-1:0] mask);
        bus.cmd_valid_i = 1; bus.cmd_op_i = op; bus.cmd_mask_i = mask;
        chk("ready_c0", 64'(bus.cmd_ready_o), 64'd1);
        cyc();
        bus.cmd_valid_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid_i = 0; bus.cmd_op_i = '0; bus.cmd_mask_i = '0;
        bus.perf_en_i = '0; bus.bypass_ack_i = '0; bus.flush_ack_i = '0;
        for (int k = 0; k < NB; k++) begin
            hit[k] = '1; trans[k] = CW'(k + 1); miss[k] = CW'(k * 16);
        end
        rst = 1; cyc(); cyc(); rst = 0;
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_byp",   64'(bus.bypass_req_o), 64'd0);
        chk("rst_done",  64'(bus.done_o), 64'd0);
        chk("rst_sum",   64'(bus.hit_sum_o), 64'd0);

        // BYP_SET 0x05, acks follow one cycle later.
        issue(3'd0, 8'h05);
        chk("bypset_c1_req", 64'(bus.bypass_req_o), 64'h05);
        chk("bypset_c1_ready", 64'(bus.cmd_ready_o), 64'd0);
        cyc(); bus.bypass_ack_i = 8'h05;
        chk("bypset_c2_done", 64'(bus.done_o), 64'd0);
        cyc();
        chk("bypset_c3_done", 64'(bus.done_o), 64'd1);
        chk("bypset_c3_ready", 64'(bus.cmd_ready_o), 64'd0);
        cyc();
        issue(3'd1, 8'h01);
        chk("bypclr_c1_req", 64'(bus.bypass_req_o), 64'h04);
        bus.bypass_ack_i = 8'h04;
        cyc();
        chk("bypclr_c2_done", 64'(bus.done_o), 64'd1);
        cyc();

        // FLUSH 0xFF, core k acks in cycle k+1; spurious ack of core 0 in cycle 5.
        issue(3'd2, 8'hFF);
        for (int c = 1; c <= 8; c++) begin
            logic [7:0] exp_req;
            exp_req = 8'hFF << (c - 1);
            bus.flush_ack_i = 8'(1 << (c - 1)) | ((c == 5) ? 8'h01 : 8'h00);
            chk("flush_req", 64'(bus.flush_req_o), 64'(exp_req));
            chk("flush_nodone", 64'(bus.done_o), 64'd0);
            cyc();
        end
        bus.flush_ack_i = '0;
        chk("flush_c9_done", 64'(bus.done_o), 64'd1);
        chk("flush_c9_req", 64'(bus.flush_req_o), 64'd0);
        cyc();

        // SUM over all cores with saturated hit counters.
        issue(3'd4, 8'hFF);
        for (int c = 1; c <= 8; c++) begin
            chk("sum_nodone", 64'(bus.done_o), 64'd0);
            cyc();
        end
        chk("sum_c9_done", 64'(bus.done_o), 64'd1);
        chk("sum_hit",   64'(bus.hit_sum_o), 64'h7_FFFF_FFF8);
        chk("sum_trans", 64'(bus.trans_sum_o), 64'd36);
        chk("sum_miss",  64'(bus.miss_sum_o), 64'd448);
        cyc();
        hit[1] = 32'd5;
        issue(3'd4, 8'h02);
        repeat (8) cyc();
        chk("sum2_done", 64'(bus.done_o), 64'd1);
        chk("sum2_hit",   64'(bus.hit_sum_o), 64'd5);
        chk("sum2_trans", 64'(bus.trans_sum_o), 64'd2);
        chk("sum2_miss",  64'(bus.miss_sum_o), 64'd16);
        hit[1] = 32'd99;
        repeat (3) cyc();
        chk("sum2_hold", 64'(bus.hit_sum_o), 64'd5);

        // CLEAR pulse, then an illegal op.
        bus.perf_en_i = 8'hA5;
        issue(3'd3, 8'h30);
        chk("clear_c1", 64'(bus.ctrl_clear_regs_o), 64'h30);
        chk("enable_reg", 64'(bus.ctrl_enable_regs_o), 64'hA5);
        cyc();
        chk("clear_c2", 64'(bus.ctrl_clear_regs_o), 64'h00);
        chk("clear_c2_done", 64'(bus.done_o), 64'd1);
        cyc();
        issue(3'd6, 8'hFF);
        chk("ill_done", 64'(bus.done_o), 64'd1);
        chk("ill_err",  64'(bus.err_o), 64'd1);
        chk("ill_byp",  64'(bus.bypass_req_o), 64'h04);
        cyc();

        // Empty-mask bypass and one-cycle flush both finish in cycle 2.
        issue(3'd0, 8'h00);
        cyc();
        chk("empty_byp_done", 64'(bus.done_o), 64'd1);
        cyc();
        issue(3'd2, 8'h03);
        bus.flush_ack_i = 8'h03;
        cyc();
        bus.flush_ack_i = '0;
        chk("fast_flush_done", 64'(bus.done_o), 64'd1);
        cyc();

        // Reset while flushing aborts without done.
        issue(3'd2, 8'h0F);
        cyc();
        chk("abort_req", 64'(bus.flush_req_o), 64'h0F);
        rst = 1;
        cyc();
        rst = 0;
        chk("abort_flush", 64'(bus.flush_req_o), 64'd0);
        chk("abort_done",  64'(bus.done_o), 64'd0);
        chk("abort_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("abort_byp",   64'(bus.bypass_req_o), 64'd0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pri_icache_ctrl_seq.md
# pri_icache_ctrl_seq

Command sequencer for the private instruction caches of a cluster with `NB_CORES` cores. It accepts one masked command at a time: bypass on, bypass off, flush, clear counters, or sum counters. It then drives the per-core bypass, flush and clear request lines and tracks each core's acknowledge. It also sequentially accumulates the per-core hit/transaction/miss counters into widened cluster totals. It sits between the cluster peripheral register file and the per-core icache control ports.

## Interface
- `NB_CORES`, 8, number of private icaches (≥1)
- `CNT_W`, 32, width of each per-core counter
- `SUM_W`, `CNT_W+$clog2(NB_CORES)`, width of each accumulated total; cannot overflow
- `clk_i` in 1 clock
- `rst_i` in 1 reset; one clock; reset is synchronous and active-high
- `cmd_valid_i` in 1 command valid
- `cmd_ready_o` out 1 high only in IDLE
- `cmd_op_i` in 3 0=BYP_SET, 1=BYP_CLR, 2=FLUSH, 3=CLEAR, 4=SUM, 5–7 illegal
- `cmd_mask_i` in `NB_CORES` target cores
- `done_o` out 1 one-cycle completion pulse
- `err_o` out 1 high with `done_o` for an illegal op, else 0
- `perf_en_i` in `NB_CORES` counter enable per core
- `bypass_req_o` / `bypass_ack_i` out/in `NB_CORES` level bypass request / state
- `flush_req_o` / `flush_ack_i` out/in `NB_CORES` flush request / acknowledge
- `ctrl_clear_regs_o` out `NB_CORES` counter clear pulse
- `ctrl_enable_regs_o` out `NB_CORES` registered copy of `perf_en_i`
- `hit_count_i`, `trans_count_i`, `miss_count_i` in `NB_CORES*CNT_W` each; core k at bits [k*CNT_W +: CNT_W]
- `hit_sum_o`, `trans_sum_o`, `miss_sum_o` out `SUM_W` each; totals from the last SUM

## Operation
- States: IDLE, BYP_WAIT, FLUSH_WAIT, CLEAR, SUM, DONE.
- A command is accepted on a cycle with `cmd_valid_i && cmd_ready_o`; call that cycle 0. The op and mask are latched on accept.
- BYP_SET / BYP_CLR
  - Next state: BYP_WAIT.
  - `bypass_req_o[k]` is set (SET) or cleared (CLR) for masked k; unmasked bits are unchanged.
  - The FSM leaves BYP_WAIT for DONE on the first cycle where `bypass_ack_i[k]==bypass_req_o[k]` for every masked k.
  - Acks of unmasked cores are ignored.
- FLUSH
  - Next state: FLUSH_WAIT with `flush_req_o=mask`.
  - In FLUSH_WAIT, each bit with `flush_req_o[k]&&flush_ack_i[k]` clears at the end of that cycle. `flush_ack_i[k]` is ignored while `flush_req_o[k]` is low.
  - The FSM goes to DONE on the cycle where `(flush_req_o & ~flush_ack_i)==0`.
- CLEAR: next state CLEAR. `ctrl_clear_regs_o=mask` for exactly that one cycle, then DONE.
- SUM
  - On accept, the three sum registers are zeroed and the core index is set to 0.
  - In SUM, the FSM adds core idx's counts to each sum if `mask[idx]`, zero-extended to `SUM_W`.
  - idx increments each cycle. After idx=`NB_CORES-1`, the FSM goes to DONE.
- Illegal op: next state DONE with `err_o=1`. No request lines change.
- DONE: `done_o=1` and `cmd_ready_o=0` for one cycle, then IDLE.
- Empty mask: BYP/FLUSH complete in their first wait cycle. SUM produces zeros.
- Sums hold between SUM commands and are stable from the DONE cycle onward.
- `ctrl_enable_regs_o` is `perf_en_i` delayed by one register, independent of the FSM.

## Timing
- Reset: state IDLE. All of these are 0: `bypass_req_o`, `flush_req_o`, `ctrl_clear_regs_o`, `ctrl_enable_regs_o`, `done_o`, `err_o`, and all sums. `cmd_ready_o` is 1 in the first cycle after reset.
- Reset mid-operation aborts the command with no `done_o`. Requests drop in the cycle after reset is sampled.
- All outputs are registered, except `cmd_ready_o`, which is decoded from the state register.
- Request outputs change in cycle 1 (the first cycle after accept).
- Latency to `done_o`:
  - BYP: 2 + n cycles, where n is the number of BYP_WAIT cycles before match (n=0 if acks already match in cycle 1).
  - FLUSH: 2 + cycles until the last ack.
  - CLEAR: cycle 2.
  - SUM: cycle `NB_CORES+1`.
  - Illegal: cycle 1.
- The next accept is possible at the earliest in the cycle after DONE.
- If a flush ack arrives in cycle 1 for every masked core, DONE is in cycle 2.

## Test plan
- Reset, then BYP_SET mask=0x05 with acks following one cycle later:
  - `bypass_req_o=0x05` in cycle 1.
  - Acks 0x05 in cycle 2, `done_o` in cycle 3.
  - Then BYP_CLR mask=0x01 gives `bypass_req_o=0x04`.
- FLUSH mask=0xFF, core k acks in cycle k+1:
  - Each `flush_req_o[k]` drops after its ack.
  - `done_o` in cycle 9.
  - A spurious ack on an already-cleared core has no effect.
- SUM mask=0xFF, hit_k=0xFFFFFFFF for all k:
  - `hit_sum_o=0x7_FFFFFFF8` at `done_o` in cycle 9.
  - A repeat with mask=0x02 and hit_1=5 gives 5.
- CLEAR mask=0x30: `ctrl_clear_regs_o=0x30` for exactly cycle 1, `done_o` in cycle 2. Op=6 gives `done_o`+`err_o` in cycle 1 and no request change.
- Assert `rst_i` in FLUSH_WAIT with `flush_req_o=0x0F`: `flush_req_o=0`, no `done_o`, `cmd_ready_o=1`, and `bypass_req_o=0` after reset.
